// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : FIFO-buffered 8N1/8P1/8x2 asynchronous serial transmitter
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                        tx_clk,
   input  logic                        reset,
   input  logic                        tx_valid,
   input  logic [7:0]                  tx_data,
   output logic                        tx_ready,
   output logic                        tx_done,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        tx
);

   localparam int c_AW        = $clog2(FIFO_DEPTH);
   localparam int c_CNTW      = c_AW + 1;
   localparam int c_STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
   localparam int c_CW        = (c_STOP_CLKS > 1) ? $clog2(c_STOP_CLKS) : 1;

   localparam logic [c_CW-1:0]   c_BIT_LAST  = c_CW'(CLKS_PER_BIT - 1);
   localparam logic [c_CW-1:0]   c_STOP_LAST = c_CW'(c_STOP_CLKS - 1);
   localparam logic [c_CNTW-1:0] c_FULL      = c_CNTW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
   logic [2:0]        r_bit, w_bit_nxt;
   logic [7:0]        r_shift, w_shift_nxt;
   logic              r_par, w_par_nxt;
   logic              r_tx, w_tx_nxt;

   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]   r_wptr, r_rptr;
   logic [c_CNTW-1:0] r_count;

   logic              w_push, w_pop, w_cnt_last;
   logic [7:0]        w_head;

   assign tx_ready   = (r_count != c_FULL);
   assign w_push     = tx_valid && tx_ready;
   assign w_head     = r_mem[r_rptr];
   // The stop period spans STOP_BITS bit times, so it has its own terminal count.
   assign w_cnt_last = (r_state == S_STOP) ? (r_cnt == c_STOP_LAST) : (r_cnt == c_BIT_LAST);

   always_ff @(posedge tx_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= tx_data;
      end
   end

   always_ff @(posedge tx_clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_pop       = 1'b0;
      w_tx_nxt    = 1'b1;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (r_count != '0) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_cnt_last) begin
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_cnt_last) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = {1'b0, r_shift[7:1]};
               w_bit_nxt   = r_bit + 1'b1;
               if (r_bit == 3'd7) begin
                  w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (w_cnt_last) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_cnt_last) begin
               w_cnt_nxt = '0;
               // Chain straight into the next frame to avoid an idle gap.
               if (r_count != '0) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase

      if (w_pop) begin
         w_shift_nxt = w_head;
         w_par_nxt   = ^w_head;
      end

      case (w_state_nxt)
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = w_shift_nxt[0];
         S_PARITY: w_tx_nxt = (PARITY == 1) ? ~w_par_nxt : w_par_nxt;
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge tx_clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_par   <= w_par_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   assign tx         = r_tx;
   assign tx_busy    = (r_state != S_IDLE);
   assign tx_done    = (r_state == S_STOP) && w_cnt_last;
   assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Scoreboard bench for uart_tx_fifo (defaults plus parity/stop variants)
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

   logic       clk;
   logic       reset;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready, tx_done, tx_busy, tx;
   logic [3:0] fifo_count;

   logic       v2;
   logic [7:0] d2, d3;
   logic       p2_ready, p2_done, p2_busy, p2_tx;
   logic       p1_ready, p1_done, p1_busy, p1_tx;
   logic       s2_ready, s2_done, s2_busy, s2_tx;
   logic [3:0] p2_count, p1_count, s2_count;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_done  = 0;
   logic       mon_en  = 1'b0;
   logic       saw_full = 1'b0;
   logic [7:0] sbq [$];

   uart_tx_fifo u_dut (
      .tx_clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .tx_done(tx_done), .tx_busy(tx_busy),
      .fifo_count(fifo_count), .tx(tx)
   );

   uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .PARITY(2), .STOP_BITS(1)) u_dut_p2 (
      .tx_clk(clk), .reset(reset), .tx_valid(v2), .tx_data(d2),
      .tx_ready(p2_ready), .tx_done(p2_done), .tx_busy(p2_busy),
      .fifo_count(p2_count), .tx(p2_tx)
   );

   uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .PARITY(1), .STOP_BITS(1)) u_dut_p1 (
      .tx_clk(clk), .reset(reset), .tx_valid(v2), .tx_data(d2),
      .tx_ready(p1_ready), .tx_done(p1_done), .tx_busy(p1_busy),
      .fifo_count(p1_count), .tx(p1_tx)
   );

   uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .PARITY(0), .STOP_BITS(2)) u_dut_s2 (
      .tx_clk(clk), .reset(reset), .tx_valid(v2), .tx_data(d3),
      .tx_ready(s2_ready), .tx_done(s2_done), .tx_busy(s2_busy),
      .fifo_count(s2_count), .tx(s2_tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Offers one byte and returns at the negedge following its acceptance, tx_valid left high.
   task automatic push(input logic [7:0] b);
      int t = 0;
      tx_valid = 1'b1;
      tx_data  = b;
      while (!tx_ready && t < 2000) begin
         if (t == 0) begin
            saw_full = 1'b1;
            check("full_count", fifo_count, 8);
         end
         @(negedge clk);
         t++;
      end
      if (t >= 2000) check("push_timeout", t, 0);
      @(negedge clk);
      if (mon_en) sbq.push_back(b);
   endtask

   task automatic drain(input int budget);
      int t = 0;
      while ((sbq.size() != 0 || tx_busy) && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("drain_timeout", (t < budget), 1);
   endtask

   initial begin : p_done_cnt
      forever begin
         @(negedge clk);
         if (tx_done === 1'b1) n_done = n_done + 1;
      end
   end

   // Serial receiver model: samples mid-bit and compares against the scoreboard.
   initial begin : p_mon
      logic [7:0] got;
      logic       expect_start;
      expect_start = 1'b0;
      forever begin
         @(negedge clk);
         if (expect_start) check("no_gap", tx, 0);
         expect_start = 1'b0;
         if (mon_en && tx === 1'b0) begin
            @(negedge clk);
            check("start_bit", tx, 0);
            for (int i = 0; i < 8; i++) begin
               repeat (4) @(negedge clk);
               got[i] = tx;
            end
            repeat (4) @(negedge clk);
            check("stop_bit", tx, 1);
            @(negedge clk);
            check("done_early", tx_done, 0);
            @(negedge clk);
            check("done_pulse", tx_done, 1);
            check("stop_last", tx, 1);
            if (sbq.size() == 0) check("sb_extra", sbq.size(), 1);
            else                 check("rx_byte", got, sbq.pop_front());
            expect_start = (sbq.size() != 0);
         end
      end
   end

   initial begin : p_watchdog
      #1000000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "bench timeout");
   end

   initial begin : p_main
      int d0;
      reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
      v2 = 1'b0; d2 = 8'h00; d3 = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_done", tx_done, 0);
      check("rst_busy", tx_busy, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ready", tx_ready, 1);
      reset = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // Single byte, latency and frame timing
      d0 = n_done;
      push(8'hA5);
      tx_valid = 1'b0;
      check("lat_tx_hi", tx, 1);
      check("lat_count1", fifo_count, 1);
      @(negedge clk);
      check("lat_tx_lo", tx, 0);
      check("lat_busy", tx_busy, 1);
      check("lat_count0", fifo_count, 0);
      drain(200);
      check("t1_done_cnt", n_done - d0, 1);

      // Nine back-to-back bytes
      d0 = n_done;
      for (int i = 0; i < 9; i++) begin
         check("t2_ready", tx_ready, 1);
         push(8'(i));
      end
      tx_valid = 1'b0;
      drain(1000);
      check("t2_done_cnt", n_done - d0, 9);

      // Producer stalled by a full FIFO, pointers wrap
      d0 = n_done;
      saw_full = 1'b0;
      for (int i = 0; i < 10; i++) push(8'h10 + 8'(i));
      tx_valid = 1'b0;
      check("t3_saw_full", saw_full, 1);
      drain(1500);
      check("t3_done_cnt", n_done - d0, 10);

      // Reset during data bit 3 with bytes queued
      mon_en = 1'b0;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      tx_valid = 1'b0;
      check("t4_busy", tx_busy, 1);
      check("t4_count", fifo_count, 2);
      repeat (16) @(negedge clk);
      check("t4_bit3", tx, 0);
      d0 = n_done;
      reset = 1'b1;
      @(negedge clk);
      check("t4_rst_tx", tx, 1);
      check("t4_rst_count", fifo_count, 0);
      check("t4_rst_busy", tx_busy, 0);
      check("t4_rst_done", tx_done, 0);
      check("t4_rst_ready", tx_ready, 1);
      reset = 1'b0;
      repeat (60) @(negedge clk);
      check("t4_no_done", n_done - d0, 0);
      check("t4_idle", tx_busy, 0);
      mon_en = 1'b1;
      push(8'h3C);
      tx_valid = 1'b0;
      drain(200);

      // Parity and two-stop-bit variants
      v2 = 1'b1; d2 = 8'h07; d3 = 8'hFF;
      @(negedge clk);
      v2 = 1'b0;
      @(negedge clk);
      check("p2_start", p2_tx, 0);
      check("s2_start", s2_tx, 0);
      check("p2_count0", p2_count, 0);
      for (int k = 1; k <= 44; k++) begin
         @(negedge clk);
         if (k == 5)  begin check("p2_bit0", p2_tx, 1); check("s2_bit0", s2_tx, 1); end
         if (k == 17) check("p2_bit3", p2_tx, 0);
         if (k == 37) begin check("par_even", p2_tx, 1); check("par_odd", p1_tx, 0); end
         if (k == 39) begin check("s2_stop1", s2_tx, 1); check("s2_done_early", s2_done, 0); end
         if (k == 41) begin check("p2_stop", p2_tx, 1); check("s2_stop2", s2_tx, 1); end
         if (k == 42) check("p2_done_early", p2_done, 0);
         if (k == 43) begin
            check("p2_done", p2_done, 1);
            check("p1_done", p1_done, 1);
            check("s2_done", s2_done, 1);
            check("s2_stop_last", s2_tx, 1);
         end
         if (k == 44) begin check("p2_idle", p2_busy, 0); check("s2_idle", s2_busy, 0); end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: the transmit end of the serial link whose receive end is rx_core.
- Accepts bytes through a valid/ready handshake into an internal FIFO.
- Serializes each byte as an asynchronous frame on tx: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Serves as the TX datapath of the UART Avalon slave, and as a multi-byte stimulus driver for rx_core benches.

Parameters:
- CLKS_PER_BIT, 4, tx_clk cycles per serial bit; legal values >= 2.
- FIFO_DEPTH, 8, byte entries; power of two, >= 2.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.

Ports:
- tx_clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- tx_valid  in  1  producer has a byte on tx_data.
- tx_data  in  8  byte to queue.
- tx_ready  out  1  FIFO can accept a byte; equals !full.
- tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit.
- tx_busy  out  1  serializer is in any state other than IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued (excludes the byte being shifted).
- tx  out  1  serial line; idle high.

Behaviour:
- Reset: synchronous and active-high. At the first tx_clk edge with reset=1:
  - tx=1, tx_done=0, tx_busy=0, fifo_count=0, tx_ready=1.
  - FIFO pointers cleared; serializer goes to IDLE.
  - Applies mid-frame too: the frame is aborted, tx returns high, and no tx_done pulse is issued.
- Push: at an edge where tx_valid && tx_ready, tx_data is written at the write pointer and fifo_count increments.
  - tx_valid while full has no effect; tx_data may change freely while tx_ready=0.
- Pop: in IDLE with fifo_count>0, the head byte is loaded into the shift register and the FSM enters START.
  - Same-edge push and pop: fifo_count unchanged, both operations take effect.
- Pointers wrap modulo FIFO_DEPTH. Full when count==FIFO_DEPTH, empty when count==0.
- Latency: a byte pushed at edge N into an empty FIFO with an idle serializer drives tx low after edge N+1, i.e. the pop happens at edge N+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - A bit counter (0..CLKS_PER_BIT-1) holds each state's output for exactly CLKS_PER_BIT cycles.
  - START: tx=0.
  - DATA: tx=shift[0]; shifts right each bit period; bit index 0..7; leaves after bit 7.
  - PARITY: entered only when PARITY!=0. Even: tx = XOR of the 8 data bits. Odd: tx = inverted XOR.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame end: tx_done is asserted for exactly one cycle, coincident with the last cycle of the stop period.
  - On the next edge the FSM pops the next byte if the FIFO is non-empty (no idle gap between frames); otherwise it returns to IDLE.
- Frame length: (10 + (PARITY!=0) + (STOP_BITS-1)) * CLKS_PER_BIT cycles.
- tx is registered and glitch-free. tx_ready and fifo_count are registered or derived from registered counts; there is no combinational path from tx_valid.

Test Plan:
- Reset, then push 0xA5 with defaults (CLKS_PER_BIT=4) -> tx low 1 cycle after acceptance for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles; tx_done pulses once, 40 cycles after tx first falls low minus 1; rx_core recovers 0xA5.
- Push 9 bytes 0x00..0x08 back-to-back, FIFO_DEPTH=8 -> first byte pops immediately; tx_ready stays 1 throughout, never deasserting; 9 frames with no idle gap; 9 tx_done pulses; rx_core sees 0x00..0x08 in order.
- Stall the producer: hold tx_valid with 10 bytes offered while a frame is in progress -> tx_ready falls when fifo_count=8; no byte is lost or duplicated; pointer wrap exercised across the 8-entry boundary.
- PARITY=2, push 0x07 -> parity bit 1; PARITY=1, push 0x07 -> parity bit 0; frame length 44 cycles.
- STOP_BITS=2, push 0xFF -> stop high for 8 cycles; tx_done at the last of them.
- Assert reset during data bit 3 with 3 bytes queued -> tx=1, fifo_count=0, tx_busy=0 one edge later; no tx_done; the next pushed byte 0x3C transmits correctly.
